// File: rtl/rob_commit_controller.sv
// rtl/rob_commit_controller.sv - in-order ROB commit sequencing with flush/redirect control
//
// Purpose: pops the ROB head when it is complete and the map can take it,
// and updates the architectural map. A committing branch head or an
// external flush request starts a FLUSH_CYCLES-long Flush with a one-cycle
// redirect, followed by one RESUME bubble. Also counts retired instructions.
//
// Ports:
//   Clk_i, Rst_i            clock (rising edge), asynchronous active-low reset
//   Head_*_i                ROB head slot: valid, PC, branch flag/target, rdst, phydst
//   Map_Ready_i             architectural map / free list can accept a commit
//   Ext_Stall_i             commit inhibit
//   Ext_Flush_i, _PC_i      exception flush pulse and its handler PC
//   Check_Commit_o          ROB pop (combinational)
//   Arch_We_o/Rdst_o/Phydst_o, Commit_PC_o   commit-stage map update
//   Flush_o, Redirect_Valid_o, Redirect_PC_o registered flush/redirect
//   Retired_Count_o         commits since reset (wraps)
//   Busy_o                  controller is not in RUN
module rob_commit_controller #(
   parameter int FLUSH_CYCLES = 2,
   parameter int PHY_W        = 6
) (
   input  logic             Clk_i,
   input  logic             Rst_i,
   input  logic             Head_Valid_i,
   input  logic [31:0]      Head_PC_i,
   input  logic             Head_Branch_i,
   input  logic [31:0]      Head_Branch_To_PC_i,
   input  logic [4:0]       Head_Rdst_i,
   input  logic [PHY_W-1:0] Head_Phydst_i,
   input  logic             Map_Ready_i,
   input  logic             Ext_Stall_i,
   input  logic             Ext_Flush_i,
   input  logic [31:0]      Ext_Flush_PC_i,
   output logic             Check_Commit_o,
   output logic             Arch_We_o,
   output logic [4:0]       Arch_Rdst_o,
   output logic [PHY_W-1:0] Arch_Phydst_o,
   output logic [31:0]      Commit_PC_o,
   output logic             Flush_o,
   output logic             Redirect_Valid_o,
   output logic [31:0]      Redirect_PC_o,
   output logic [31:0]      Retired_Count_o,
   output logic             Busy_o
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FLUSH  = 2'd1,
      RESUME = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        flush_q;
   logic        redirect_valid_q;
   logic [31:0] redirect_pc_q;
   logic [31:0] retired_count_q;

   logic        in_run;
   logic        check_commit;
   logic        flush_event;
   logic [31:0] redirect_pc_d;
   logic [31:0] retired_count_d;

   assign in_run = (state_q == RUN);

   // Ext_Flush suppresses the pop so the excepting head is not retired.
   assign check_commit = in_run & Head_Valid_i & Map_Ready_i & ~Ext_Stall_i & ~Ext_Flush_i;

   // A branch only flushes once it actually retires; a blocked branch waits.
   assign flush_event     = in_run & (Ext_Flush_i | (check_commit & Head_Branch_i));
   assign redirect_pc_d   = Ext_Flush_i ? Ext_Flush_PC_i : Head_Branch_To_PC_i;
   assign retired_count_d = retired_count_q + {31'd0, check_commit};

   always_ff @(posedge Clk_i or negedge Rst_i) begin
      if (!Rst_i) begin
         state_q          <= RUN;
         cnt_q            <= 4'd0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= 32'd0;
         retired_count_q  <= 32'd0;
      end else begin
         retired_count_q <= retired_count_d;
         unique case (state_q)
            RUN: begin
               if (flush_event) begin
                  state_q          <= FLUSH;
                  cnt_q            <= CNT_LOAD;
                  flush_q          <= 1'b1;
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= redirect_pc_d;
               end
            end
            FLUSH: begin
               // Redirect is a single pulse in the first flush cycle only.
               redirect_valid_q <= 1'b0;
               if (cnt_q == 4'd0) begin
                  state_q <= RESUME;
                  flush_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESUME: begin
               // One bubble so ROB pointers settle after the flush.
               state_q <= RUN;
            end
            default: begin
               state_q <= RUN;
               flush_q <= 1'b0;
            end
         endcase
      end
   end

   assign Check_Commit_o   = check_commit;
   assign Arch_We_o        = check_commit & (Head_Rdst_i != 5'd0);
   assign Arch_Rdst_o      = Head_Rdst_i;
   assign Arch_Phydst_o    = Head_Phydst_i;
   assign Commit_PC_o      = Head_PC_i;
   assign Flush_o          = flush_q;
   assign Redirect_Valid_o = redirect_valid_q;
   assign Redirect_PC_o    = redirect_pc_q;
   assign Retired_Count_o  = retired_count_q;
   assign Busy_o           = ~in_run;

endmodule

// File: tb/tb_rob_commit_controller.sv
// tb/tb_rob_commit_controller.sv - self-checking bench for rob_commit_controller
module tb_rob_commit_controller;

   localparam int F     = 2;
   localparam int PHY_W = 6;

   logic             clk;
   logic             rst_n;
   logic             hv, br, mr, st, ef;
   logic [31:0]      hpc, bpc, efpc;
   logic [4:0]       rd;
   logic [PHY_W-1:0] pd;
   logic             cc, we, fl, rv, busy;
   logic [4:0]       a_rd;
   logic [PHY_W-1:0] a_pd;
   logic [31:0]      c_pc, rpc, rcnt;

   int n_cmp = 0;
   int n_err = 0;

   rob_commit_controller #(.FLUSH_CYCLES(F), .PHY_W(PHY_W)) dut (
      .Clk_i(clk), .Rst_i(rst_n),
      .Head_Valid_i(hv), .Head_PC_i(hpc), .Head_Branch_i(br),
      .Head_Branch_To_PC_i(bpc), .Head_Rdst_i(rd), .Head_Phydst_i(pd),
      .Map_Ready_i(mr), .Ext_Stall_i(st), .Ext_Flush_i(ef), .Ext_Flush_PC_i(efpc),
      .Check_Commit_o(cc), .Arch_We_o(we), .Arch_Rdst_o(a_rd), .Arch_Phydst_o(a_pd),
      .Commit_PC_o(c_pc), .Flush_o(fl), .Redirect_Valid_o(rv), .Redirect_PC_o(rpc),
      .Retired_Count_o(rcnt), .Busy_o(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        hv, mr, st, ef, br;
      logic [4:0]  rd;
      logic [31:0] bpc, efpc;
      logic        e_cc, e_we, e_fl, e_rv, e_busy;
      logic [31:0] e_cnt, e_rpc;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      hv = 0; br = 0; mr = 0; st = 0; ef = 0;
      hpc = 0; bpc = 0; efpc = 0; rd = 0; pd = 0;
   endtask

   // Holds reset for two cycles, checks reset values, releases 1 after an edge.
   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_flush", fl, 0);
      chk("rst_rv", rv, 0);
      chk("rst_rpc", rpc, 0);
      chk("rst_cnt", rcnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cc", cc, 0);
      rst_n = 1;
   endtask

   // Reference model: tracks only the cycle of the last flush event.
   int          m_cyc, m_ev;
   logic [31:0] m_cnt, m_rpc;

   task automatic model_reset();
      m_cyc = 0; m_ev = -1000; m_cnt = 0; m_rpc = 0;
   endtask

   task automatic model_check_and_step();
      logic e_fl, e_rv, e_busy, e_cc, e_we;
      e_fl   = (m_cyc >= m_ev + 1) && (m_cyc <= m_ev + F);
      e_rv   = (m_cyc == m_ev + 1);
      e_busy = (m_cyc >= m_ev + 1) && (m_cyc <= m_ev + F + 1);
      e_cc   = !e_busy && hv && mr && !st && !ef;
      e_we   = e_cc && (rd != 0);
      chk("rnd_cc", cc, e_cc);
      chk("rnd_we", we, e_we);
      chk("rnd_flush", fl, e_fl);
      chk("rnd_rv", rv, e_rv);
      chk("rnd_busy", busy, e_busy);
      chk("rnd_rpc", rpc, m_rpc);
      chk("rnd_cnt", rcnt, m_cnt);
      chk("rnd_pass", {a_rd, a_pd, c_pc[20:0]}, {rd, pd, hpc[20:0]});
      if (!e_busy && (ef || (e_cc && br))) begin
         m_ev  = m_cyc;
         m_rpc = ef ? efpc : bpc;
      end
      if (e_cc) m_cnt = m_cnt + 1;
      m_cyc++;
   endtask

   initial begin
      // hv mr st ef br rd bpc efpc | cc we fl rv busy cnt rpc
      vecs.push_back('{1,1,0,0,0, 3, 0, 0,           1,1,0,0,0, 0, 0});
      vecs.push_back('{1,1,0,0,0, 4, 0, 0,           1,1,0,0,0, 1, 0});
      vecs.push_back('{1,1,0,0,0, 5, 0, 0,           1,1,0,0,0, 2, 0});
      vecs.push_back('{1,1,0,0,0, 6, 0, 0,           1,1,0,0,0, 3, 0});
      vecs.push_back('{1,1,0,0,0, 0, 0, 0,           1,0,0,0,0, 4, 0});
      vecs.push_back('{0,1,0,0,0, 2, 0, 0,           0,0,0,0,0, 5, 0});
      vecs.push_back('{1,1,0,0,1, 7, 32'h00400100, 0, 1,1,0,0,0, 5, 0});
      vecs.push_back('{1,1,0,0,0, 8, 0, 0,           0,0,1,1,1, 6, 32'h00400100});
      vecs.push_back('{1,1,0,0,0, 8, 0, 0,           0,0,1,0,1, 6, 32'h00400100});
      vecs.push_back('{1,1,0,0,0, 8, 0, 0,           0,0,0,0,1, 6, 32'h00400100});
      vecs.push_back('{1,1,0,0,0, 1, 0, 0,           1,1,0,0,0, 6, 32'h00400100});
      vecs.push_back('{1,1,0,1,1, 9, 32'h11111111, 32'h80000180, 0,0,0,0,0, 7, 32'h00400100});
      vecs.push_back('{1,1,0,0,0, 9, 0, 0,           0,0,1,1,1, 7, 32'h80000180});
      vecs.push_back('{0,1,0,1,0, 9, 0, 32'hDEADBEEF, 0,0,1,0,1, 7, 32'h80000180});
      vecs.push_back('{1,1,0,0,0, 9, 0, 0,           0,0,0,0,1, 7, 32'h80000180});
      vecs.push_back('{1,0,0,0,0, 9, 0, 0,           0,0,0,0,0, 7, 32'h80000180});
      vecs.push_back('{1,0,0,0,0, 9, 0, 0,           0,0,0,0,0, 7, 32'h80000180});
      vecs.push_back('{1,0,0,0,0, 9, 0, 0,           0,0,0,0,0, 7, 32'h80000180});
      vecs.push_back('{1,1,1,0,0, 9, 0, 0,           0,0,0,0,0, 7, 32'h80000180});
      vecs.push_back('{1,1,1,0,0, 9, 0, 0,           0,0,0,0,0, 7, 32'h80000180});
      vecs.push_back('{1,1,0,0,0, 2, 0, 0,           1,1,0,0,0, 7, 32'h80000180});

      @(negedge clk);
      do_reset();

      // Table phase: inputs applied 1 after an edge, sampled 2 later.
      for (int i = 0; i < vecs.size(); i++) begin
         hv = vecs[i].hv; mr = vecs[i].mr; st = vecs[i].st; ef = vecs[i].ef;
         br = vecs[i].br; rd = vecs[i].rd; pd = 6'(vecs[i].rd);
         bpc = vecs[i].bpc; efpc = vecs[i].efpc; hpc = 32'h1000 + 32'(i * 4);
         #2;
         chk($sformatf("v%0d_cc", i), cc, vecs[i].e_cc);
         chk($sformatf("v%0d_we", i), we, vecs[i].e_we);
         chk($sformatf("v%0d_flush", i), fl, vecs[i].e_fl);
         chk($sformatf("v%0d_rv", i), rv, vecs[i].e_rv);
         chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
         chk($sformatf("v%0d_cnt", i), rcnt, vecs[i].e_cnt);
         chk($sformatf("v%0d_rpc", i), rpc, vecs[i].e_rpc);
         @(posedge clk); #1;
      end
      idle_inputs();
      #2;
      chk("table_final_cnt", rcnt, 8);
      @(posedge clk); #1;

      // Reset asserted during the second flush cycle.
      hv = 1; mr = 1; br = 1; rd = 3; bpc = 32'h00400100;
      @(posedge clk); #1;
      br = 0; hv = 0;
      #2;
      chk("mid_first_flush", fl, 1);
      @(posedge clk); #1;
      chk("mid_second_flush", fl, 1);
      rst_n = 0;
      #1;
      chk("mid_rst_flush", fl, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cnt", rcnt, 0);
      chk("mid_rst_rv", rv, 0);
      @(posedge clk); #1;
      rst_n = 1;
      hv = 1; mr = 1; rd = 4;
      #2;
      chk("post_rst_cc", cc, 1);
      @(posedge clk); #1;
      hv = 0;
      #2;
      chk("post_rst_cnt", rcnt, 1);
      @(posedge clk); #1;

      // Randomized phase against the reference model.
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         hv   = ($urandom_range(0, 3) != 0);
         mr   = ($urandom_range(0, 4) != 0);
         st   = ($urandom_range(0, 7) == 0);
         ef   = ($urandom_range(0, 19) == 0);
         br   = ($urandom_range(0, 5) == 0);
         rd   = 5'($urandom);
         pd   = PHY_W'($urandom);
         hpc  = $urandom;
         bpc  = $urandom;
         efpc = $urandom;
         #2;
         model_check_and_step();
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
